// File: rtl/clock_alarm_core.sv
// HH:MM:SS time-of-day counter with a settable alarm, a five-button adjust FSM
// and a timed alarm ringer. All outputs are registered. Time and alarm are stored as BCD.
module clock_alarm_core #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int RING_SECS = 30,
  parameter int HOURS_MAX = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_c,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic        btn_u,
  input  logic        btn_d,
  input  logic        alarm_en,
  output logic [15:0] disp_bcd,
  output logic [3:0]  digit_blank,
  output logic [7:0]  sec_bcd,
  output logic [2:0]  mode,
  output logic        alarm_ring,
  output logic        sec_led
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(TICK_DIV / 2);
  localparam logic [7:0] HR_MAX_BCD  = {4'(HOURS_MAX / 10), 4'(HOURS_MAX % 10)};
  localparam logic [7:0] MIN_MAX_BCD = 8'h59;
  localparam logic [7:0] RING_LAST   = 8'(RING_SECS - 1);

  localparam logic [2:0] S_RUN       = 3'd0;
  localparam logic [2:0] S_ADJ_T_HR  = 3'd1;
  localparam logic [2:0] S_ADJ_T_MIN = 3'd2;
  localparam logic [2:0] S_ADJ_A_HR  = 3'd3;
  localparam logic [2:0] S_ADJ_A_MIN = 3'd4;
  localparam logic [2:0] S_RINGING   = 3'd5;

  // Wrapping BCD step of a two-digit field whose largest value is vmax.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
    if (v == vmax)              bcd_inc = 8'h00;
    else if (v[3:0] == 4'd9)    bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else                        bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] vmax);
    if (v == 8'h00)             bcd_dec = vmax;
    else if (v[3:0] == 4'd0)    bcd_dec = {v[7:4] - 4'd1, 4'd9};
    else                        bcd_dec = {v[7:4], v[3:0] - 4'd1};
  endfunction

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_state;
  logic [7:0]    r_hr, r_min, r_sec, r_ahr, r_amin, r_ring_cnt;
  logic [15:0]   r_disp;
  logic [3:0]    r_blank;
  logic          r_ring, r_sec_led;

  logic [CW-1:0] w_cnt_nxt;
  logic          w_tick, w_any_btn, w_hit, w_sel_hr, w_sel_alm, w_led_clr, w_led_nxt;
  logic [7:0]    w_sec_adv, w_min_adv, w_hr_adv;
  logic [7:0]    w_fld, w_fld_max, w_fld_new;
  logic [2:0]    w_state_nxt;
  logic [7:0]    w_hr_nxt, w_min_nxt, w_sec_nxt, w_ahr_nxt, w_amin_nxt, w_ring_nxt;
  logic [15:0]   w_disp_nxt;
  logic [3:0]    w_blank_nxt;

  always_comb begin
    w_tick    = (r_cnt == CNT_LAST);
    w_cnt_nxt = w_tick ? '0 : r_cnt + CW'(1);
    w_any_btn = btn_c | btn_l | btn_r | btn_u | btn_d;

    // Time as it would be after this cycle's tick, with sec->min->hr carries.
    w_sec_adv = w_tick ? bcd_inc(r_sec, MIN_MAX_BCD) : r_sec;
    w_min_adv = (w_tick && (r_sec == MIN_MAX_BCD)) ? bcd_inc(r_min, MIN_MAX_BCD) : r_min;
    w_hr_adv  = (w_tick && (r_sec == MIN_MAX_BCD) && (r_min == MIN_MAX_BCD)) ?
                bcd_inc(r_hr, HR_MAX_BCD) : r_hr;
    w_hit     = alarm_en && w_tick && (w_sec_adv == 8'h00) &&
                (w_hr_adv == r_ahr) && (w_min_adv == r_amin);

    w_sel_hr  = (r_state == S_ADJ_T_HR) || (r_state == S_ADJ_A_HR);
    w_sel_alm = (r_state == S_ADJ_A_HR) || (r_state == S_ADJ_A_MIN);
    w_fld_max = w_sel_hr ? HR_MAX_BCD : MIN_MAX_BCD;
    w_fld     = w_sel_alm ? (w_sel_hr ? r_ahr : r_amin) : (w_sel_hr ? r_hr : r_min);
    w_fld_new = btn_u ? bcd_inc(w_fld, w_fld_max) : bcd_dec(w_fld, w_fld_max);

    w_state_nxt = r_state;
    w_hr_nxt    = r_hr;
    w_min_nxt   = r_min;
    w_sec_nxt   = r_sec;
    w_ahr_nxt   = r_ahr;
    w_amin_nxt  = r_amin;
    w_ring_nxt  = r_ring_cnt;
    w_led_clr   = 1'b0;

    case (r_state)
      S_RUN: begin
        w_hr_nxt  = w_hr_adv;
        w_min_nxt = w_min_adv;
        w_sec_nxt = w_sec_adv;
        if (btn_c) begin
          w_state_nxt = S_ADJ_T_HR;
          w_sec_nxt   = 8'h00;
        end else if (w_hit) begin
          w_state_nxt = S_RINGING;
          w_ring_nxt  = 8'd0;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_ADJ_T_HR, S_ADJ_T_MIN, S_ADJ_A_HR, S_ADJ_A_MIN: begin
        if (btn_c) begin
          w_state_nxt = S_RUN;
          w_led_clr   = 1'b1;
        end else if (btn_l) begin
          w_state_nxt = (r_state == S_ADJ_T_HR) ? S_ADJ_A_MIN : r_state - 3'd1;
        end else if (btn_r) begin
          w_state_nxt = (r_state == S_ADJ_A_MIN) ? S_ADJ_T_HR : r_state + 3'd1;
        end else if (btn_u || btn_d) begin
          case ({w_sel_alm, w_sel_hr})
            2'b00:   w_min_nxt  = w_fld_new;
            2'b01:   w_hr_nxt   = w_fld_new;
            2'b10:   w_amin_nxt = w_fld_new;
            2'b11:   w_ahr_nxt  = w_fld_new;
            default: w_min_nxt  = r_min;
          endcase
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_RINGING: begin
        w_hr_nxt  = w_hr_adv;
        w_min_nxt = w_min_adv;
        w_sec_nxt = w_sec_adv;
        // A button press only silences the alarm; it has no other effect here.
        if (w_any_btn || !alarm_en) begin
          w_state_nxt = S_RUN;
        end else if (w_tick) begin
          if (r_ring_cnt == RING_LAST) w_state_nxt = S_RUN;
          else                         w_ring_nxt  = r_ring_cnt + 8'd1;
        end else begin
          w_state_nxt = S_RINGING;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase

    w_led_nxt = w_led_clr ? 1'b0 : (w_cnt_nxt < CNT_HALF);

    if ((w_state_nxt == S_ADJ_A_HR) || (w_state_nxt == S_ADJ_A_MIN)) begin
      w_disp_nxt = {w_ahr_nxt, w_amin_nxt};
    end else begin
      w_disp_nxt = {w_hr_nxt, w_min_nxt};
    end

    if (!w_led_nxt) begin
      case (w_state_nxt)
        S_ADJ_T_HR, S_ADJ_A_HR:   w_blank_nxt = 4'b1100;
        S_ADJ_T_MIN, S_ADJ_A_MIN: w_blank_nxt = 4'b0011;
        default:                  w_blank_nxt = 4'b0000;
      endcase
    end else begin
      w_blank_nxt = 4'b0000;
    end
  end

  // State, time, alarm and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_state    <= S_RUN;
      r_hr       <= 8'h00;
      r_min      <= 8'h00;
      r_sec      <= 8'h00;
      r_ahr      <= 8'h00;
      r_amin     <= 8'h00;
      r_ring_cnt <= 8'd0;
      r_disp     <= 16'h0000;
      r_blank    <= 4'b0000;
      r_ring     <= 1'b0;
      r_sec_led  <= 1'b1;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_state    <= w_state_nxt;
      r_hr       <= w_hr_nxt;
      r_min      <= w_min_nxt;
      r_sec      <= w_sec_nxt;
      r_ahr      <= w_ahr_nxt;
      r_amin     <= w_amin_nxt;
      r_ring_cnt <= w_ring_nxt;
      r_disp     <= w_disp_nxt;
      r_blank    <= w_blank_nxt;
      r_ring     <= (w_state_nxt == S_RINGING);
      r_sec_led  <= w_led_nxt;
    end
  end

  assign disp_bcd    = r_disp;
  assign digit_blank = r_blank;
  assign sec_bcd     = r_sec;
  assign mode        = r_state;
  assign alarm_ring  = r_ring;
  assign sec_led     = r_sec_led;

endmodule

// File: tb/tb_clock_alarm_core.sv
// Bench for clock_alarm_core: a seconds-of-day model checked every cycle,
// plus directed scenarios with literal expectations and a 12-hour build.
module tb_clock_alarm_core;
  localparam int TD = 4;
  localparam int RS = 3;
  localparam int HN = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_c = 1'b0, btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
  logic alarm_en = 1'b0;
  logic [15:0] disp_bcd;
  logic [3:0]  digit_blank;
  logic [7:0]  sec_bcd;
  logic [2:0]  mode;
  logic        alarm_ring, sec_led;

  logic b12_c = 1'b0, b12_l = 1'b0, b12_r = 1'b0, b12_u = 1'b0, b12_d = 1'b0;
  logic [15:0] disp12;
  logic [3:0]  blank12;
  logic [7:0]  sec12;
  logic [2:0]  mode12;
  logic        ring12, led12;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  clock_alarm_core #(.TICK_DIV(TD), .RING_SECS(RS), .HOURS_MAX(23)) dut (
    .clk(clk), .rst(rst), .btn_c(btn_c), .btn_l(btn_l), .btn_r(btn_r),
    .btn_u(btn_u), .btn_d(btn_d), .alarm_en(alarm_en), .disp_bcd(disp_bcd),
    .digit_blank(digit_blank), .sec_bcd(sec_bcd), .mode(mode),
    .alarm_ring(alarm_ring), .sec_led(sec_led));

  clock_alarm_core #(.TICK_DIV(TD), .RING_SECS(RS), .HOURS_MAX(11)) dut12 (
    .clk(clk), .rst(rst), .btn_c(b12_c), .btn_l(b12_l), .btn_r(b12_r),
    .btn_u(b12_u), .btn_d(b12_d), .alarm_en(1'b0), .disp_bcd(disp12),
    .digit_blank(blank12), .sec_bcd(sec12), .mode(mode12),
    .alarm_ring(ring12), .sec_led(led12));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] bcd2(input int v);
    bcd2 = {4'(v / 10), 4'(v % 10)};
  endfunction

  // Behavioural model: plain integer time-of-day, mode numbers as in the port description.
  int m_hh, m_mm, m_ss, m_ahh, m_amm, m_cnt, m_mode, m_ring;
  bit m_clr;

  always @(posedge clk or posedge rst) begin : model
    int t, btn, hh, mm, ss, ahh, amm, md, rc;
    bit tick, hit;
    if (rst) begin
      m_hh <= 0; m_mm <= 0; m_ss <= 0; m_ahh <= 0; m_amm <= 0;
      m_cnt <= 0; m_mode <= 0; m_ring <= 0; m_clr <= 1'b0;
    end else begin
      tick = (m_cnt == TD - 1);
      btn = btn_c ? 1 : btn_l ? 2 : btn_r ? 3 : btn_u ? 4 : btn_d ? 5 : 0;
      hh = m_hh; mm = m_mm; ss = m_ss; ahh = m_ahh; amm = m_amm; md = m_mode; rc = m_ring;
      if ((m_mode == 0 || m_mode == 5) && tick) begin
        t = (m_hh * 3600 + m_mm * 60 + m_ss + 1) % (HN * 3600);
        hh = t / 3600; mm = (t / 60) % 60; ss = t % 60;
      end
      hit = alarm_en && tick && ss == 0 && hh == m_ahh && mm == m_amm;
      if (m_mode == 0) begin
        if (btn == 1) begin md = 1; ss = 0; end
        else if (hit) begin md = 5; rc = 0; end
      end else if (m_mode == 5) begin
        if (btn != 0 || !alarm_en) md = 0;
        else if (tick) begin
          rc = rc + 1;
          if (rc == RS) md = 0;
        end
      end else begin
        case (btn)
          1: md = 0;
          2: md = (m_mode == 1) ? 4 : m_mode - 1;
          3: md = (m_mode == 4) ? 1 : m_mode + 1;
          4, 5: begin
            case (m_mode)
              1: hh  = (hh  + ((btn == 4) ? 1 : HN - 1)) % HN;
              2: mm  = (mm  + ((btn == 4) ? 1 : 59)) % 60;
              3: ahh = (ahh + ((btn == 4) ? 1 : HN - 1)) % HN;
              default: amm = (amm + ((btn == 4) ? 1 : 59)) % 60;
            endcase
          end
          default: md = m_mode;
        endcase
      end
      m_clr  <= (m_mode >= 1 && m_mode <= 4 && btn == 1);
      m_cnt  <= (m_cnt + 1) % TD;
      m_hh <= hh; m_mm <= mm; m_ss <= ss; m_ahh <= ahh; m_amm <= amm;
      m_mode <= md; m_ring <= rc;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic exp_led;
    logic [3:0] exp_blank;
    logic [15:0] exp_disp;
    if (chk_en) begin
      exp_led = m_clr ? 1'b0 : (m_cnt < TD / 2);
      exp_disp = (m_mode == 3 || m_mode == 4) ? {bcd2(m_ahh), bcd2(m_amm)}
                                              : {bcd2(m_hh), bcd2(m_mm)};
      exp_blank = 4'b0000;
      if (!exp_led && (m_mode == 1 || m_mode == 3)) exp_blank = 4'b1100;
      if (!exp_led && (m_mode == 2 || m_mode == 4)) exp_blank = 4'b0011;
      chk("model_disp", disp_bcd, exp_disp);
      chk("model_blank", digit_blank, exp_blank);
      chk("model_sec", sec_bcd, bcd2(m_ss));
      chk("model_mode", mode, m_mode[2:0]);
      chk("model_ring", alarm_ring, (m_mode == 5));
      chk("model_led", sec_led, exp_led);
    end
  end

  // Buttons order: {c, l, r, u, d}; held for exactly one active edge.
  task automatic press(input logic [4:0] b);
    @(negedge clk);
    #1 {btn_c, btn_l, btn_r, btn_u, btn_d} = b;
    @(posedge clk);
    #1 {btn_c, btn_l, btn_r, btn_u, btn_d} = 5'b00000;
  endtask

  task automatic press12(input logic [4:0] b);
    @(negedge clk);
    #1 {b12_c, b12_l, b12_r, b12_u, b12_d} = b;
    @(posedge clk);
    #1 {b12_c, b12_l, b12_r, b12_u, b12_d} = 5'b00000;
  endtask

  task automatic wait_ring(input string name);
    int n;
    n = 0;
    while (mode !== 3'd5 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, mode, 3'd5);
  endtask

  localparam logic [4:0] C = 5'b10000, L = 5'b01000, R = 5'b00100, U = 5'b00010, D = 5'b00001;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_disp", disp_bcd, 16'h0000);
    chk("rst_blank", digit_blank, 4'b0000);
    chk("rst_sec", sec_bcd, 8'h00);
    chk("rst_mode", mode, 3'd0);
    chk("rst_ring", alarm_ring, 1'b0);
    chk("rst_led", sec_led, 1'b1);
    chk_en = 1'b1;

    // Asynchronous reset in the middle of a second.
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_disp", disp_bcd, 16'h0000);
    chk("arst_sec", sec_bcd, 8'h00);
    chk("arst_mode", mode, 3'd0);
    chk("arst_ring", alarm_ring, 1'b0);
    @(negedge clk) rst = 1'b0;

    // Set 23:59 and roll over after one minute.
    press(C); press(D); press(R); press(D); press(C);
    chk("set_2359", disp_bcd, 16'h2359);
    chk("set_sec0", sec_bcd, 8'h00);
    repeat (240) @(posedge clk);
    #1;
    chk("roll_disp", disp_bcd, 16'h0000);
    chk("roll_sec", sec_bcd, 8'h00);

    // Hour wraps after 24 increments; L from hour goes to alarm minutes.
    press(C);
    for (int i = 0; i < 24; i++) press(U);
    chk("hr_wrap", disp_bcd[15:8], 8'h00);
    press(L);
    chk("l_to_amin", mode, 3'd4);
    press(U);
    chk("alarm_0001", disp_bcd, 16'h0001);
    alarm_en = 1'b1;
    press(C);
    chk("exit_led", sec_led, 1'b0);

    // Alarm rings at 00:01:00 and auto-stops after three ticks.
    wait_ring("ring_start");
    chk("ring_on", alarm_ring, 1'b1);
    chk("ring_time", disp_bcd, 16'h0001);
    repeat (11) @(posedge clk);
    #1 chk("ring_still", mode, 3'd5);
    @(posedge clk);
    #1;
    chk("ring_auto_mode", mode, 3'd0);
    chk("ring_auto_off", alarm_ring, 1'b0);

    // Button silences ringing without other effect.
    press(C); press(L); press(U); press(C);
    wait_ring("ring2_start");
    press(U);
    chk("btn_stop_mode", mode, 3'd0);
    chk("btn_stop_ring", alarm_ring, 1'b0);
    chk("btn_stop_disp", disp_bcd, 16'h0002);

    // Disarming stops ringing.
    press(C); press(L); press(U); press(C);
    wait_ring("ring3_start");
    @(negedge clk) alarm_en = 1'b0;
    @(posedge clk);
    #1 chk("disarm_mode", mode, 3'd0);

    // C and U together: C wins, hours blink.
    press(C | U);
    chk("cu_mode", mode, 3'd1);
    chk("cu_disp", disp_bcd, 16'h0003);
    for (int n = 0; n < 8 && sec_led !== 1'b0; n++) begin @(posedge clk); #1; end
    chk("blink_on", digit_blank, 4'b1100);
    for (int n = 0; n < 8 && sec_led !== 1'b1; n++) begin @(posedge clk); #1; end
    chk("blink_off", digit_blank, 4'b0000);
    press(C);

    // 12-hour build.
    press12(C); press12(D);
    chk("h12_dec", disp12[15:8], 8'h11);
    press12(U);
    chk("h12_wrap", disp12[15:8], 8'h00);

    repeat (8) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
